// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// instruction opcodes, ALU-op classes and R-type function codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU decode: ALU-op class plus R-type funct -> 3-bit ALU control.
module alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            ALUOP_ADD: alucontrol = 3'b010;
            ALUOP_SUB: alucontrol = 3'b110;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = 3'b010;
                    FN_SUB:  alucontrol = 3'b110;
                    FN_AND:  alucontrol = 3'b000;
                    FN_OR:   alucontrol = 3'b001;
                    FN_SLT:  alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch, decode,
// execute, memory and writeback, plus datapath enables and selects.
module main_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pcen,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic       pcwrite, branch, irwrite_s, regwrite_s, memwrite_s, mem_req_s;
    logic [1:0] aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            // op is expected stable from the IR; anything else falls back to fetch
            S_MEMADR: begin
                if (op == OP_LW)      state_d = S_MEMRD;
                else if (op == OP_SW) state_d = S_MEMWR;
                else                  state_d = S_FETCH;
            end
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        mem_req_s  = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                alusrcb   = 2'b01;
                irwrite_s = mem_ready;
                pcwrite   = mem_ready;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord      = 1'b1;
                mem_req_s = 1'b1;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_req_s  = 1'b1;
                memwrite_s = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite_s = 1'b1;
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    alu_dec u_alu_dec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    // Reset gates the side-effecting strobes directly so FETCH's request
    // never leaks out while reset is held, regardless of clk or mem_ready.
    assign pcen     = ~reset & (pcwrite | (branch & zero));
    assign irwrite  = ~reset & irwrite_s;
    assign regwrite = ~reset & regwrite_s;
    assign memwrite = ~reset & memwrite_s;
    assign mem_req  = ~reset & mem_req_s;
    assign state    = state_q;

endmodule
